// File: rtl/muldiv_unit.sv
// Iterative 32-iteration multiply/divide unit that owns the HI/LO register pair.
// Shift-add multiply (LSB first) and restoring divide (MSB first) under a start/busy/done handshake.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               dz_q;

    // Operand/working registers: loaded on accept, stepped in CALC, never reset.
    logic               is_div_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;

    logic signed [WIDTH-1:0] rs_s, rt_s;
    logic                    is_signed;
    logic [WIDTH-1:0]        opa, opb;
    logic                    accept, last;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;

    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quo_res, rem_res;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? WIDTH'(-v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix_sign_wide(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (2*WIDTH)'(-v) : v;
    endfunction

    assign rs_s      = rs_data;
    assign rt_s      = rt_data;
    assign is_signed = op[0];
    assign opa       = is_signed ? abs_val(rs_s) : rs_data;
    assign opb       = is_signed ? abs_val(rt_s) : rt_data;

    assign accept = start && !flush && (state != S_CALC);
    assign last   = (state == S_CALC) && (cnt == CNT_W'(WIDTH - 1));

    assign busy    = (state == S_CALC);
    assign done    = (state == S_DONE);
    assign divzero = (state == S_DONE) && dz_q;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CALC;
            S_CALC:  if (last) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_CALC : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // One iteration: multiply adds the multiplicand when the multiplier LSB is set,
    // divide trial-subtracts the divisor from the shifted partial remainder.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        acc_step  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ok    = !div_diff[WIDTH];
        rem_step  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_step  = {quo_q[WIDTH-2:0], div_ok};
    end

    // Divide by zero leaves the remainder equal to |rs|, so the normal remainder
    // fixup already restores rs_data; only the quotient needs overriding.
    always_comb begin
        prod_res = fix_sign_wide(acc_step, neg_res_q);
        quo_res  = dz_q ? '1 : fix_sign(quo_step, neg_res_q);
        rem_res  = fix_sign(rem_step, neg_rem_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
            dz_q  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt  <= '0;
                dz_q <= op[1] && (rt_data == '0);
            end else if (state == S_CALC) begin
                cnt <= cnt + 1'b1;
            end
            if (last && !flush) begin
                if (is_div_q) begin
                    hi <= rem_res;
                    lo <= quo_res;
                end else begin
                    hi <= prod_res[2*WIDTH-1:WIDTH];
                    lo <= prod_res[WIDTH-1:0];
                end
            end else if (state != S_CALC) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            is_div_q  <= op[1];
            neg_res_q <= is_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_rem_q <= is_signed && rs_data[WIDTH-1];
            opnd_q    <= op[1] ? opb : opa;
            acc_q     <= {{WIDTH{1'b0}}, opb};
            rem_q     <= '0;
            quo_q     <= opa;
        end else if (state == S_CALC) begin
            acc_q <= acc_step;
            rem_q <= rem_step;
            quo_q <= quo_step;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus randomized ops
// compared against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RST, start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data, wdata;
    logic        busy, done, divzero;
    logic [31:0] hi, lo;

    int vec_count = 0;
    int err_count = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // HI/LO reference computed with 64-bit integer arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ez = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'd0: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
            2'd1: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    el = 32'hFFFFFFFF; eh = a; ez = 1'b1;
                end else if (o == 2'd2) begin
                    el = a / b; eh = a % b;
                end else begin
                    q = sa / sb; r = sa % sb;
                    el = q[31:0]; eh = r[31:0];
                end
            end
        endcase
    endfunction

    // Issues one op and waits (bounded) for done; leaves time inside the DONE cycle.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cyc, output int lat, output bit to);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1; busy_cyc = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cyc++;
            tick();
            lat++;
        end
        to = !done;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        tick(); tick();
        vec_count++;
        if ({busy, done, divzero} !== 3'b000) begin
            err_count++; $display("FAIL reset_flags: got %b expected 000", {busy, done, divzero});
        end
        vec_count++;
        if ({hi, lo} !== 64'd0) begin
            err_count++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
        end
        RST = 1'b0;
        tick();
        vec_count++;
        if (busy !== 1'b0) begin
            err_count++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_multu;
        int bc, lat; bit to;
        do_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, lat, to);
        vec_count++;
        if (lat !== 33 || to) begin
            err_count++; $display("FAIL multu_latency: got %0d expected 33", lat);
        end
        vec_count++;
        if (bc !== 32) begin
            err_count++; $display("FAIL multu_busy_cycles: got %0d expected 32", bc);
        end
        vec_count++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            err_count++; $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", hi, lo);
        end
        vec_count++;
        if (divzero !== 1'b0) begin
            err_count++; $display("FAIL multu_divzero: got %b expected 0", divzero);
        end
        tick();
        vec_count++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            err_count++; $display("FAIL multu_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_mult_div;
        int bc, lat; bit to;
        do_op(2'd1, 32'hFFFFFFF9, 32'd3, bc, lat, to);
        vec_count++;
        if (to || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
            err_count++; $display("FAIL mult_neg: got %h_%h expected ffffffff_ffffffeb", hi, lo);
        end
        tick();
        do_op(2'd3, 32'hFFFFFFF9, 32'd2, bc, lat, to);
        vec_count++;
        if (to || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            err_count++; $display("FAIL div_neg: got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", hi, lo);
        end
        tick();
    endtask

    task automatic test_divzero;
        int bc, lat; bit to;
        do_op(2'd2, 32'h1234, 32'd0, bc, lat, to);
        vec_count++;
        if (to || lo !== 32'hFFFFFFFF || hi !== 32'h1234 || divzero !== 1'b1) begin
            err_count++; $display("FAIL divu_zero: got hi=%h lo=%h dz=%b expected 00001234 ffffffff 1", hi, lo, divzero);
        end
        tick();
        vec_count++;
        if (divzero !== 1'b0) begin
            err_count++; $display("FAIL divzero_gated: got %b expected 0", divzero);
        end
        do_op(2'd3, 32'hFFFFFF00, 32'd0, bc, lat, to);
        vec_count++;
        if (to || lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFF00 || divzero !== 1'b1) begin
            err_count++; $display("FAIL div_neg_zero: got hi=%h lo=%h dz=%b expected ffffff00 ffffffff 1", hi, lo, divzero);
        end
        tick();
        do_op(2'd3, 32'h80000000, 32'hFFFFFFFF, bc, lat, to);
        vec_count++;
        if (to || lo !== 32'h80000000 || hi !== 32'd0 || divzero !== 1'b0) begin
            err_count++; $display("FAIL div_overflow: got hi=%h lo=%h dz=%b expected 0 80000000 0", hi, lo, divzero);
        end
        tick();
    endtask

    task automatic test_flush;
        int bc, lat; bit to;
        logic [31:0] ph, pl;
        bit saw_done;
        ph = hi; pl = lo;
        op = 2'd2; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vec_count++;
        if (busy !== 1'b0) begin
            err_count++; $display("FAIL flush_busy: got %b expected 0", busy);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        vec_count++;
        if (saw_done !== 1'b0) begin
            err_count++; $display("FAIL flush_no_done: got %b expected 0", saw_done);
        end
        vec_count++;
        if (hi !== ph || lo !== pl) begin
            err_count++; $display("FAIL flush_hilo_kept: got %h_%h expected %h_%h", hi, lo, ph, pl);
        end
        do_op(2'd2, 32'd100, 32'd7, bc, lat, to);
        vec_count++;
        if (to || lo !== 32'd14 || hi !== 32'd2) begin
            err_count++; $display("FAIL flush_restart: got hi=%0d lo=%0d expected 2 14", hi, lo);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int bc, lat; bit to;
        bit dropped;
        do_op(2'd0, 32'd6, 32'd7, bc, lat, to);
        vec_count++;
        if (to || lo !== 32'd42 || hi !== 32'd0) begin
            err_count++; $display("FAIL b2b_first: got %h_%h expected 0_0000002a", hi, lo);
        end
        op = 2'd0; rs_data = 32'd3; rt_data = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1; dropped = 1'b0;
        while (!done && lat < 100) begin
            if (!busy) dropped = 1'b1;
            tick();
            lat++;
        end
        vec_count++;
        if (dropped !== 1'b0) begin
            err_count++; $display("FAIL b2b_busy_gap: got %b expected 0", dropped);
        end
        vec_count++;
        if (lat !== 33) begin
            err_count++; $display("FAIL b2b_latency: got %0d expected 33", lat);
        end
        vec_count++;
        if (lo !== 32'd15 || hi !== 32'd0) begin
            err_count++; $display("FAIL b2b_result: got %h_%h expected 0_0000000f", hi, lo);
        end
        tick();
    endtask

    task automatic test_regwrite_reset;
        logic [31:0] pl;
        hi_we = 1'b1; wdata = 32'hA5A5A5A5;
        tick();
        hi_we = 1'b0;
        vec_count++;
        if (hi !== 32'hA5A5A5A5) begin
            err_count++; $display("FAIL mthi_idle: got %h expected a5a5a5a5", hi);
        end
        lo_we = 1'b1; wdata = 32'h0BADF00D;
        tick();
        lo_we = 1'b0;
        vec_count++;
        if (lo !== 32'h0BADF00D) begin
            err_count++; $display("FAIL mtlo_idle: got %h expected 0badf00d", lo);
        end
        pl = lo;
        op = 2'd0; rs_data = 32'd9; rt_data = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        lo_we = 1'b1; wdata = 32'h12345678;
        tick();
        lo_we = 1'b0;
        vec_count++;
        if (lo !== pl || busy !== 1'b1) begin
            err_count++; $display("FAIL mtlo_calc_ignored: got lo=%h busy=%b expected %h 1", lo, busy, pl);
        end
        repeat (5) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        vec_count++;
        if ({busy, done, divzero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            err_count++; $display("FAIL reset_mid_calc: got flags=%b hi=%h lo=%h expected 000 0 0", {busy, done, divzero}, hi, lo);
        end
        tick();
    endtask

    task automatic test_random;
        int bc, lat; bit to;
        logic [1:0]  o;
        logic [31:0] a, b, eh, el;
        logic        ez;
        int          sel;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            if (sel == 1) b = $urandom_range(1, 15);
            if (sel == 2) a = 32'h80000000;
            if (sel == 3) b = 32'hFFFFFFFF;
            model(o, a, b, eh, el, ez);
            do_op(o, a, b, bc, lat, to);
            vec_count++;
            if (to || lat !== 33) begin
                err_count++; $display("FAIL rand_latency[%0d]: got %0d expected 33", i, lat);
            end
            vec_count++;
            if (hi !== eh || lo !== el) begin
                err_count++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h_%h expected %h_%h", i, o, a, b, hi, lo, eh, el);
            end
            vec_count++;
            if (divzero !== ez) begin
                err_count++; $display("FAIL rand_divzero[%0d]: got %b expected %b", i, divzero, ez);
            end
        end
        tick();
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'd0; rs_data = '0; rt_data = '0; wdata = '0;
        test_reset();
        test_multu();
        test_mult_div();
        test_divzero();
        test_flush();
        test_back_to_back();
        test_regwrite_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit owning the HI/LO register pair for the MIPS datapath. It sits beside the single-cycle ALU in execute and handles MULT, MULTU, DIV and DIVU. Each operation runs as a fixed-latency, 32-iteration shift-add or restoring-divide sequence under a start/busy/done handshake. The pipeline stalls on `busy` and reads results through `hi` and `lo`.

## Interface
- `WIDTH`, 32, operand and HI/LO width; iteration count equals `WIDTH`.
- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE or DONE.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with `start`.
- `rs_data`  in  WIDTH  multiplicand / dividend; sampled with `start`.
- `rt_data`  in  WIDTH  multiplier / divisor; sampled with `start`.
- `flush`  in  1  abort the in-flight operation (branch/exception squash).
- `hi_we`, `lo_we`  in  1 each  MTHI/MTLO write enables.
- `wdata`  in  WIDTH  MTHI/MTLO write data.
- `busy`  out  1  high while in CALC.
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold the new result that cycle.
- `divzero`  out  1  qualifies `done`: the completed divide had `rt_data == 0`.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO registers.

## Operation
- **FSM states:** IDLE, CALC, DONE.
  - IDLE + `start` -> CALC.
  - CALC with iteration count 31 -> DONE.
  - DONE + `start` -> CALC; otherwise DONE -> IDLE.
  - `flush` in any state -> IDLE. It wins over `start` in the same cycle.
- **On accept:**
  - Latch `op`.
  - Signed ops (MULT, DIV) latch operand absolute values, plus result-sign and remainder-sign flags.
  - Unsigned ops latch the operands raw.
  - Clear the 5-bit counter.
- **Multiply:** radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- **Divide:** restoring division, one quotient bit per cycle, MSB first. Uses a 33-bit partial remainder.
- **Result commit (CALC -> DONE edge):**
  - Multiply: `{hi,lo}` = product, negated in 64-bit two's complement if the signs differ.
  - Divide: `lo` = quotient, negated if the operand signs differ. `hi` = remainder, negated if the dividend was negative.
- **Divide by zero:** the divide still runs the full 32 iterations.
  - `lo` = 0xFFFFFFFF and `hi` = `rs_data`, with no sign fixup, for both DIV and DIVU.
  - `divzero` = 1 with `done`.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF gives `lo` = 0x80000000, `hi` = 0, `divzero` = 0.
- **MTHI/MTLO writes:**
  - Take effect when `busy` = 0.
  - Ignored while `busy` = 1. The pipeline must not issue them then.
  - A write in the same cycle as the commit edge is dropped; the commit wins.
- **Flush:** `hi`/`lo` stay unchanged. No `done` pulse is produced.
- **Start in CALC:** ignored.

## Timing
- **Reset values:** state IDLE; `busy` = 0, `done` = 0, `divzero` = 0; `hi` = 0, `lo` = 0; counter = 0.
- **Latency:**
  - `start` sampled at edge N.
  - `busy` = 1 for cycles N+1 through N+32.
  - `done` = 1 and new `hi`/`lo` visible in cycle N+33.
  - Total: 33 cycles from accept to result.
- **Back-to-back:** `start` during the DONE cycle is accepted. `busy` rises the next cycle, so there are no idle bubbles.
- **Outputs:** `busy`, `done` and `divzero` are decoded from registered state (no combinational path from inputs). `divzero` is 0 whenever `done` is 0.
- **Reset mid-operation:** `RST` at any edge returns all outputs to reset values at the next cycle.
- **Register writes:** `hi_we`/`lo_we` writes are visible on `hi`/`lo` the cycle after the edge.

## Test plan
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles `hi` = 0xFFFFFFFE, `lo` = 0x00000001, `done` for exactly 1 cycle, `busy` high for exactly 32 cycles.
- **MULT:** -7 (0xFFFFFFF9) × 3 -> `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB. Then DIV -7 / 2 -> `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- **DIVU by zero:** 0x1234 / 0 -> `lo` = 0xFFFFFFFF, `hi` = 0x1234, `divzero` = 1 with `done`. DIV 0x80000000 / -1 -> `lo` = 0x80000000, `hi` = 0, `divzero` = 0.
- **Flush:** assert `flush` at iteration 10 of DIVU 100 / 7 -> `busy` = 0 next cycle, `hi`/`lo` keep their prior values, no `done`. A restarted DIVU 100 / 7 -> `lo` = 14, `hi` = 2.
- **Back-to-back:** `start` MULTU 3 × 5 in the DONE cycle of a prior op -> `busy` never drops, second `done` 33 cycles after the first, `lo` = 15.
- **Register writes and reset:** `hi_we` with 0xA5A5A5A5 in IDLE -> `hi` = 0xA5A5A5A5 next cycle; `lo_we` during CALC ignored. `RST` mid-CALC -> all outputs 0 next cycle.
